ysyx_prf_freelist: RTL

YSYX_PRF_FREELIST -- requirements
Module: ysyx_prf_freelist

---
 rtl/ysyx_prf_freelist_pkg.sv | 21 ++
 rtl/ysyx_prf_freelist.sv | 107 ++++++++++
 2 files changed

// File: rtl/ysyx_prf_freelist_pkg.sv
// ysyx_prf_freelist_pkg
//   Shared defaults for the physical register free list.
//   The widths come from the ysyx.svh global macros. They get fallback
//   values here so the block also builds on its own.
//   Exports:
//     DEF_PLEN : default physical register index width
//     DEF_RLEN : default architectural register index width

`ifndef YSYX_PHY_LEN
`define YSYX_PHY_LEN 6
`endif
`ifndef YSYX_REG_LEN
`define YSYX_REG_LEN 5
`endif

package ysyx_prf_freelist_pkg;

  localparam int DEF_PLEN = `YSYX_PHY_LEN;
  localparam int DEF_RLEN = `YSYX_REG_LEN;

endpackage

// File: rtl/ysyx_prf_freelist.sv
// ysyx_prf_freelist
//   Circular free list of physical registers for a renaming pipeline.
//   Allocation proceeds speculatively from spec_head. Retirement frees the
//   stale mapping at tail and moves arch_head forward. A flush rewinds
//   spec_head to arch_head, which returns every in-flight allocation.
//   Ports:
//     clock, reset             : rising-edge clock, synchronous active-high reset
//     alloc_req                : rename asks for one destination prd
//     alloc_valid, alloc_prd   : a free prd exists / the prd at spec_head
//     cmt_valid, cmt_wen       : an instruction retires / it had allocated a prd
//     cmt_prs                  : stale prd released by the retiring instruction
//     flush                    : pipeline flush
//     free_cnt                 : speculatively free entries (tail - spec_head)
//   All outputs come from registered state only.

module ysyx_prf_freelist
  import ysyx_prf_freelist_pkg::*;
#(
  parameter int PLEN = DEF_PLEN,
  parameter int RLEN = DEF_RLEN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            alloc_req,
  output logic            alloc_valid,
  output logic [PLEN-1:0] alloc_prd,
  input  logic            cmt_valid,
  input  logic            cmt_wen,
  input  logic [PLEN-1:0] cmt_prs,
  input  logic            flush,
  output logic [PLEN:0]   free_cnt
);

  localparam int NPR   = 1 << PLEN;
  localparam int NARCH = 1 << RLEN;
  localparam int FL    = NPR - NARCH;

  logic [PLEN-1:0] entry [NPR];
  logic [PLEN:0]   spec_head;
  logic [PLEN:0]   arch_head;
  logic [PLEN:0]   tail;

  logic            alloc_fire;
  logic            rel_fire;
  logic [PLEN:0]   arch_head_next;
  logic [PLEN:0]   spec_head_next;
  logic [PLEN:0]   tail_next;

  assign alloc_valid = (tail != spec_head);
  assign alloc_prd   = entry[spec_head[PLEN-1:0]];
  assign free_cnt    = tail - spec_head;

  assign alloc_fire = alloc_req & alloc_valid & ~flush;
  assign rel_fire   = cmt_valid & cmt_wen;

  // A flush rewinds to the arch head as it will be after this cycle.
  // A retirement in the same cycle therefore counts as committed.
  always_comb begin
    arch_head_next = arch_head;
    tail_next      = tail;
    spec_head_next = spec_head;
    if (rel_fire) begin
      arch_head_next = arch_head + 1'b1;
      tail_next      = tail + 1'b1;
    end
    if (flush) begin
      spec_head_next = arch_head_next;
    end else if (alloc_fire) begin
      spec_head_next = spec_head + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      spec_head <= '0;
      arch_head <= '0;
      tail      <= (PLEN+1)'(FL);
    end else begin
      spec_head <= spec_head_next;
      arch_head <= arch_head_next;
      tail      <= tail_next;
    end
  end

  // At reset, only the first FL slots are seeded with prds NARCH..NPR-1.
  // The rest hold nothing live until the ring wraps onto them.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FL; i++) begin
        entry[i] <= PLEN'(NARCH + i);
      end
    end else if (rel_fire) begin
      entry[tail[PLEN-1:0]] <= cmt_prs;
    end
  end

  logic [PLEN:0] occupancy;
  assign occupancy = tail - arch_head;

  a_no_release_zero : assert property (@(posedge clock) disable iff (reset)
    !(rel_fire && (cmt_prs == '0)));
  a_no_overflow : assert property (@(posedge clock) disable iff (reset)
    !(rel_fire && (occupancy == (PLEN+1)'(NPR))));
  a_no_alloc_empty : assert property (@(posedge clock) disable iff (reset)
    !(alloc_fire && (free_cnt == '0)));

endmodule
